// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector: 1..MAX_LEN bit pattern, overlapping or
// non-overlapping, with Mealy and registered match outputs plus a saturating match counter.
module seq_detector_prog #(
  parameter int                 MAX_LEN = 8,
  parameter int                 LEN_W   = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'('b0110),
  parameter int                 DEF_LEN = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               valid,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               cnt_clr,
  output logic               z,
  output logic               z_q,
  output logic [CNT_W-1:0]   match_cnt
);

  logic [MAX_LEN-1:0] pat;
  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   fill;
  logic               load_ok;
  logic               accept;
  logic               fill_ok;

  function automatic logic [LEN_W-1:0] fill_sat(input logic [LEN_W-1:0] f);
    return (f == LEN_W'(MAX_LEN)) ? f : f + LEN_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_next(input logic clr, input logic hit,
                                                input logic [CNT_W-1:0] cur);
    if (clr)
      return hit ? CNT_W'(1) : '0;
    if (hit && cur != {CNT_W{1'b1}})
      return cur + CNT_W'(1);
    return cur;
  endfunction

  // An out-of-range length turns the load into a no-op so the bit is still consumed.
  assign load_ok = pat_load && (len_in != '0) && (len_in <= LEN_W'(MAX_LEN));
  assign accept  = valid && !load_ok && !reset;
  assign cand    = (hist << 1) | MAX_LEN'(x);
  assign mask    = ~({MAX_LEN{1'b1}} << len);
  // Requiring len fresh bits keeps reset/cleared history from forming a match.
  assign fill_ok = ({1'b0, fill} + (LEN_W + 1)'(1)) >= {1'b0, len};
  assign z       = accept && fill_ok && ((cand & mask) == (pat & mask));

  always_ff @(posedge clk) begin
    if (reset) begin
      pat       <= DEF_PAT;
      len       <= LEN_W'(DEF_LEN);
      hist      <= '0;
      fill      <= '0;
      z_q       <= 1'b0;
      match_cnt <= '0;
    end else begin
      z_q       <= z;
      match_cnt <= cnt_next(cnt_clr, z, match_cnt);
      if (load_ok) begin
        pat  <= pat_in;
        len  <= len_in;
        hist <= '0;
        fill <= '0;
      end else if (valid) begin
        hist <= cand;
        fill <= (z && !overlap) ? '0 : fill_sat(fill);
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench for seq_detector_prog: directed scenarios plus random traffic against a
// queue-based reference model of the detector.
module tb_seq_detector_prog;

  localparam int ML = 8;
  localparam int LW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset, x, valid, overlap, pat_load, cnt_clr;
  logic [ML-1:0] pat_in;
  logic [LW-1:0] len_in;
  logic          z, z_q;
  logic [CW-1:0] match_cnt;

  seq_detector_prog #(.MAX_LEN(ML), .LEN_W(LW), .CNT_W(CW), .DEF_PAT(8'b0110), .DEF_LEN(4)) dut (
    .clk(clk), .reset(reset), .x(x), .valid(valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .len_in(len_in), .cnt_clr(cnt_clr),
    .z(z), .z_q(z_q), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [ML-1:0] mpat;
  int            mlen;
  bit            q[$];
  int            fresh;
  logic          mzq;
  int            mcnt;
  logic          zs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_load_ok();
    return pat_load && len_in >= 1 && len_in <= ML;
  endfunction

  // Last mlen bits received, in arrival order, against pattern bits len-1 downto 0.
  function automatic logic model_z();
    bit b;
    if (reset || !valid || m_load_ok()) return 1'b0;
    if (fresh + 1 < mlen) return 1'b0;
    for (int k = 0; k < mlen; k++) begin
      b = (k == mlen - 1) ? x : q[q.size() - (mlen - 1) + k];
      if (b != mpat[mlen-1-k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_update(input logic ez);
    if (reset) begin
      mpat = 8'b0110; mlen = 4; q.delete(); fresh = 0; mzq = 0; mcnt = 0;
      return;
    end
    mzq = ez;
    if (cnt_clr) mcnt = ez ? 1 : 0;
    else if (ez && mcnt < (1 << CW) - 1) mcnt++;
    if (m_load_ok()) begin
      mpat = pat_in; mlen = len_in; q.delete(); fresh = 0;
    end else if (valid) begin
      q.push_back(x);
      if (q.size() > ML) void'(q.pop_front());
      if (ez && !overlap) fresh = 0;
      else if (fresh < ML) fresh++;
    end
  endtask

  task automatic step(input logic r, input logic xi, input logic vi, input logic li,
                      input logic [ML-1:0] pi, input logic [LW-1:0] leni, input logic ci);
    logic ez;
    reset = r; x = xi; valid = vi; pat_load = li; pat_in = pi; len_in = leni; cnt_clr = ci;
    #2;
    ez = model_z();
    zs = z;
    chk("z", z, ez);
    @(posedge clk);
    model_update(ez);
    #1;
    chk("z_q", z_q, mzq);
    chk("match_cnt", match_cnt, mcnt);
  endtask

  task automatic send(input logic b);
    step(1'b0, b, 1'b1, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i]);
      if (gaps) begin
        int g;
        g = $urandom_range(1, 3);
        for (int j = 0; j < g; j++)
          step(1'b0, 1'($urandom), 1'b0, 1'b0, '0, '0, 1'b0);
      end
    end
  endtask

  initial begin
    reset = 1'b1; x = 0; valid = 0; overlap = 1; pat_load = 0; cnt_clr = 0;
    pat_in = '0; len_in = '0;
    mpat = 8'b0110; mlen = 4; fresh = 0; mzq = 0; mcnt = 0;
    @(posedge clk); #1;

    do_reset();
    chk("rst_z_q", z_q, 0);
    chk("rst_cnt", match_cnt, 0);

    // Overlapping stream 0110110
    overlap = 1;
    send_bits(16'b0110110, 7, 0);
    chk("ovl_last_z", zs, 1);
    chk("ovl_cnt", match_cnt, 2);

    // Non-overlapping, then a fresh 0110
    do_reset();
    overlap = 0;
    send_bits(16'b0110110, 7, 0);
    chk("novl_last_z", zs, 0);
    chk("novl_cnt", match_cnt, 1);
    send_bits(16'b0110, 4, 0);
    chk("novl_z11", zs, 1);
    chk("novl_cnt2", match_cnt, 2);

    // Valid gaps with toggling x
    do_reset();
    overlap = 1;
    send_bits(16'b0110110, 7, 1);
    chk("gap_cnt", match_cnt, 2);

    // All-zero pattern must not match on empty history
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 4'd4, 1'b0);
    send_bits(16'b000, 3, 0);
    chk("zero_z3", zs, 0);
    send(1'b0);
    chk("zero_z4", zs, 1);
    send(1'b0);
    chk("zero_z5", zs, 1);

    // Load mid-stream discards the bit and history; len_in=0 load is ignored
    do_reset();
    send_bits(16'b10, 2, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'b101, 4'd3, 1'b0);
    chk("load_z", zs, 0);
    send(1'b1);
    chk("after_load_z", zs, 0);
    send_bits(16'b01, 2, 0);
    chk("p101_z", zs, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 4'd0, 1'b0);
    send_bits(16'b01, 2, 0);
    chk("badload_z", zs, 1);

    // Counter saturation, clear-with-match, reset mid-stream
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 4'd1, 1'b0);
    send_bits(16'b11111, 5, 0);
    chk("sat_cnt", match_cnt, 3);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b1);
    chk("clr_hit_cnt", match_cnt, 1);
    send(1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    chk("rst_mid_z", zs, 0);
    chk("rst_mid_zq", z_q, 0);
    chk("rst_mid_cnt", match_cnt, 0);
    send_bits(16'b011, 3, 0);
    chk("def_pat_z3", zs, 0);
    send(1'b0);
    chk("def_pat_z4", zs, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic          r, l, c, v;
      logic [LW-1:0] ln;
      if ($urandom_range(0, 7) == 0) overlap = ~overlap;
      r  = ($urandom_range(0, 99) == 0);
      l  = ($urandom_range(0, 24) == 0);
      c  = ($urandom_range(0, 15) == 0);
      v  = ($urandom_range(0, 3) != 0);
      ln = ($urandom_range(0, 1) == 0) ? LW'($urandom_range(1, 3)) : LW'($urandom_range(0, 15));
      step(r, 1'($urandom), v, l, ML'($urandom), ln, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
